// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types, default sizes and helpers for the N-port SRAM wrapper
//
// Contents:
//   SRAM_DEPTH / SRAM_DATA_W / SRAM_ADDR_W : default configuration.
//   BE_W, IDX_W                            : byte lanes per word and word index width.
//   sram_req_t {addr, we, be, wdata}       : one request channel (default widths).
//   sram_rsp_t {rdata, err}                : one response channel (default widths).
//   even_parity()                          : parity bit stored alongside each byte lane.
package sram_pkg;

  localparam int SRAM_DEPTH  = 256;
  localparam int SRAM_DATA_W = 32;
  localparam int SRAM_ADDR_W = 32;
  localparam int BE_W        = SRAM_DATA_W / 8;
  localparam int IDX_W       = $clog2(SRAM_DEPTH);

  typedef struct packed {
    logic [SRAM_ADDR_W-1:0] addr;
    logic                   we;
    logic [BE_W-1:0]        be;
    logic [SRAM_DATA_W-1:0] wdata;
  } sram_req_t;

  typedef struct packed {
    logic [SRAM_DATA_W-1:0] rdata;
    logic                   err;
  } sram_rsp_t;

  // Even parity: the stored bit makes the total count of ones in byte+parity even.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/sram_bank.sv
// rtl/sram_bank.sv - single-port word array with byte-enabled write and registered word read
//
// Optional feature macro: SRAM_PARITY_EN (per-lane even parity storage and read check).
//
// Ports:
//   clk_i    : clock.
//   en_i     : access this cycle (legal, granted).
//   we_i     : 1 = write, 0 = read.
//   idx_i    : word index.
//   be_i     : byte-lane write enables.
//   wdata_i  : write data.
//   rdata_o  : word read on the previous enabled read (registered).
//   perr_o   : parity mismatch on that read (always 0 without parity).
module sram_bank
  import sram_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32
) (
  input  logic                       clk_i,
  input  logic                       en_i,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   idx_i,
  input  logic [DATA_W/8-1:0]        be_i,
  input  logic [DATA_W-1:0]          wdata_i,
  output logic [DATA_W-1:0]          rdata_o,
  output logic                       perr_o
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < NB; b++) begin
          if (be_i[b]) mem[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end else begin
        rdata_q <= mem[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;

`ifdef SRAM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic          perr_d;
  logic          perr_q;

  always_comb begin
    perr_d = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if (par_mem[idx_i][b] != even_parity(mem[idx_i][b*8 +: 8])) perr_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < NB; b++) begin
          if (be_i[b]) par_mem[idx_i][b] <= even_parity(wdata_i[b*8 +: 8]);
        end
      end else begin
        perr_q <= perr_d;
      end
    end
  end

  assign perr_o = perr_q;
`else
  assign perr_o = 1'b0;
`endif

endmodule

// File: rtl/sram_nport_wrap.sv
// rtl/sram_nport_wrap.sv - round-robin N-port front end onto one single-port SRAM bank
//
// Optional feature macro: SRAM_PARITY_EN (parity errors reported on err_o).
//
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset.
//   req_i/gnt_o       : per-port request / combinational grant.
//   addr_i            : per-port byte address.
//   we_i, be_i        : per-port write flag and byte enables.
//   wdata_i           : per-port write data.
//   rvalid_o          : per-port response valid, one cycle after the grant.
//   rdata_o, err_o    : per-port response data / error, qualified by rvalid_o.
//   illegal_memory_o  : sticky flag for any granted out-of-window access.
module sram_nport_wrap
  import sram_pkg::*;
#(
  parameter int                NUM_PORTS = 2,
  parameter int                DEPTH     = 256,
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NUM_PORTS-1:0]                req_i,
  output logic [NUM_PORTS-1:0]                gnt_o,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]    addr_i,
  input  logic [NUM_PORTS-1:0]                we_i,
  input  logic [NUM_PORTS-1:0][DATA_W/8-1:0]  be_i,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]    wdata_i,
  output logic [NUM_PORTS-1:0]                rvalid_o,
  output logic [NUM_PORTS-1:0][DATA_W-1:0]    rdata_o,
  output logic [NUM_PORTS-1:0]                err_o,
  output logic                                illegal_memory_o
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IW    = $clog2(DEPTH);
  localparam int RR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [RR_W-1:0]      rr_q;
  logic [RR_W-1:0]      gnt_idx;
  logic [RR_W-1:0]      rr_next;
  logic                 any_gnt;

  logic [ADDR_W-1:0]    sel_addr;
  logic                 sel_we;
  logic                 legal;
  logic [IW-1:0]        idx;

  logic [NUM_PORTS-1:0] rvalid_q;
  logic [NUM_PORTS-1:0] ill_q;
  logic [NUM_PORTS-1:0] rd_q;
  logic                 illegal_q;

  logic [DATA_W-1:0]    bank_rdata;
  logic                 bank_perr;

  // Round-robin search starting at rr_q; sum is one bit wider so the wrap
  // is a single conditional subtract.
  always_comb begin
    logic [RR_W:0] sum;
    gnt_o   = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    sum     = '0;
    if (!rst_i) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        sum = {1'b0, rr_q} + (RR_W+1)'(i);
        if (sum >= (RR_W+1)'(NUM_PORTS)) sum = sum - (RR_W+1)'(NUM_PORTS);
        if (!any_gnt && req_i[sum[RR_W-1:0]]) begin
          any_gnt               = 1'b1;
          gnt_o[sum[RR_W-1:0]]  = 1'b1;
          gnt_idx               = sum[RR_W-1:0];
        end
      end
    end
  end

  assign rr_next = (gnt_idx == RR_W'(NUM_PORTS-1)) ? '0 : gnt_idx + RR_W'(1);

  // Window decode on the granted request; low byte-offset bits are dropped.
  assign sel_addr = addr_i[gnt_idx];
  assign sel_we   = we_i[gnt_idx];
  assign legal    = (sel_addr >= BASE_ADDR) &&
                    (((sel_addr - BASE_ADDR) >> (OFF_W + IW)) == '0);
  assign idx      = IW'((sel_addr - BASE_ADDR) >> OFF_W);

  sram_bank #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_bank (
    .clk_i   (clk_i),
    .en_i    (any_gnt && legal),
    .we_i    (sel_we),
    .idx_i   (idx),
    .be_i    (be_i[gnt_idx]),
    .wdata_i (wdata_i[gnt_idx]),
    .rdata_o (bank_rdata),
    .perr_o  (bank_perr)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q      <= '0;
      rvalid_q  <= '0;
      ill_q     <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      rvalid_q <= gnt_o;
      ill_q    <= gnt_o & {NUM_PORTS{!legal}};
      rd_q     <= gnt_o & {NUM_PORTS{legal && !sel_we}};
      if (any_gnt) begin
        rr_q <= rr_next;
        if (!legal) illegal_q <= 1'b1;
      end
    end
  end

  // A response due in a reset cycle is suppressed; only one port can hold a
  // response at a time, so the shared bank read word is steered to it.
  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    err_o    = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rvalid_o[p] = rvalid_q[p] && !rst_i;
      if (rvalid_o[p]) begin
        if (rd_q[p]) rdata_o[p] = bank_rdata;
        err_o[p] = ill_q[p] || (rd_q[p] && bank_perr);
      end
    end
  end

  assign illegal_memory_o = illegal_q;

endmodule

// File: tb/tb_sram_nport_wrap.sv
// tb/tb_sram_nport_wrap.sv - directed table-driven bench for sram_nport_wrap
module tb_sram_nport_wrap;

  logic             clk;
  logic             rst;
  logic [1:0]       req;
  logic [1:0]       gnt;
  logic [1:0][31:0] addr;
  logic [1:0]       we;
  logic [1:0][3:0]  be;
  logic [1:0][31:0] wdata;
  logic [1:0]       rvalid;
  logic [1:0][31:0] rdata;
  logic [1:0]       err;
  logic             ill;

  int checks = 0;
  int errors = 0;

  sram_nport_wrap #(
    .NUM_PORTS (2),
    .DEPTH     (256),
    .DATA_W    (32),
    .ADDR_W    (32),
    .BASE_ADDR (32'h0)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_i            (req),
    .gnt_o            (gnt),
    .addr_i           (addr),
    .we_i             (we),
    .be_i             (be),
    .wdata_i          (wdata),
    .rvalid_o         (rvalid),
    .rdata_o          (rdata),
    .err_o            (err),
    .illegal_memory_o (ill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [31:0] a0;
    logic        w0;
    logic [3:0]  b0;
    logic [31:0] d0;
    logic [31:0] a1;
    logic        w1;
    logic [3:0]  b1;
    logic [31:0] d1;
    logic [1:0]  gnt;
    logic [1:0]  rv;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic [1:0]  er;
    logic        ill;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [1:0] r,
    input logic [31:0] a0, input logic w0, input logic [3:0] b0, input logic [31:0] d0,
    input logic [31:0] a1, input logic w1, input logic [3:0] b1, input logic [31:0] d1,
    input logic [1:0] g, input logic [1:0] rv, input logic [31:0] rd0, input logic [31:0] rd1,
    input logic [1:0] er, input logic il);
    vec_t v;
    v.req = r;  v.a0 = a0; v.w0 = w0; v.b0 = b0; v.d0 = d0;
    v.a1 = a1;  v.w1 = w1; v.b1 = b1; v.d1 = d1;
    v.gnt = g;  v.rv = rv; v.rd0 = rd0; v.rd1 = rd1; v.er = er; v.ill = il;
    return v;
  endfunction

  task automatic drive(input logic [1:0] r,
                       input logic [31:0] a0, input logic w0, input logic [3:0] b0, input logic [31:0] d0,
                       input logic [31:0] a1, input logic w1, input logic [3:0] b1, input logic [31:0] d1);
    req = r;
    addr[0] = a0; we[0] = w0; be[0] = b0; wdata[0] = d0;
    addr[1] = a1; we[1] = w1; be[1] = b1; wdata[1] = d1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rr starts at 0 after reset; each row: inputs this cycle, gnt this
    // cycle, and the response registered from the previous row's grant.
    vt[0]  = mk(2'b01, 32'h00C, 1, 4'hF, 32'd69,       32'h0, 0, 4'h0, 32'h0,
                2'b01, 2'b00, 32'h0, 32'h0, 2'b00, 0);
    vt[1]  = mk(2'b01, 32'h00C, 0, 4'h0, 32'h0,        32'h0, 0, 4'h0, 32'h0,
                2'b01, 2'b01, 32'h0, 32'h0, 2'b00, 0);
    vt[2]  = mk(2'b00, 32'h0,   0, 4'h0, 32'h0,        32'h0, 0, 4'h0, 32'h0,
                2'b00, 2'b01, 32'd69, 32'h0, 2'b00, 0);
    vt[3]  = mk(2'b11, 32'h00C, 0, 4'h0, 32'h0,        32'h00C, 0, 4'h0, 32'h0,
                2'b10, 2'b00, 32'h0, 32'h0, 2'b00, 0);
    vt[4]  = mk(2'b11, 32'h00C, 0, 4'h0, 32'h0,        32'h00C, 0, 4'h0, 32'h0,
                2'b01, 2'b10, 32'h0, 32'd69, 2'b00, 0);
    vt[5]  = mk(2'b10, 32'h0,   0, 4'h0, 32'h0,        32'h020, 1, 4'hF, 32'hAABBCCDD,
                2'b10, 2'b01, 32'd69, 32'h0, 2'b00, 0);
    vt[6]  = mk(2'b10, 32'h0,   0, 4'h0, 32'h0,        32'h020, 1, 4'b0101, 32'h11223344,
                2'b10, 2'b10, 32'h0, 32'h0, 2'b00, 0);
    vt[7]  = mk(2'b01, 32'h020, 0, 4'hF, 32'h0,        32'h0, 0, 4'h0, 32'h0,
                2'b01, 2'b10, 32'h0, 32'h0, 2'b00, 0);
    vt[8]  = mk(2'b10, 32'h0,   0, 4'h0, 32'h0,        32'h400, 0, 4'hF, 32'h0,
                2'b10, 2'b01, 32'hAA22CC44, 32'h0, 2'b00, 0);
    vt[9]  = mk(2'b01, 32'h3FC, 1, 4'hF, 32'hDEADBEEF, 32'h0, 0, 4'h0, 32'h0,
                2'b01, 2'b10, 32'h0, 32'h0, 2'b10, 1);
    vt[10] = mk(2'b11, 32'h3FE, 0, 4'h0, 32'h0,        32'hFFFFFFFC, 1, 4'hF, 32'h12345678,
                2'b10, 2'b01, 32'h0, 32'h0, 2'b00, 1);
    vt[11] = mk(2'b01, 32'h3FE, 0, 4'h0, 32'h0,        32'h0, 0, 4'h0, 32'h0,
                2'b01, 2'b10, 32'h0, 32'h0, 2'b10, 1);
    vt[12] = mk(2'b00, 32'h0,   0, 4'h0, 32'h0,        32'h0, 0, 4'h0, 32'h0,
                2'b00, 2'b01, 32'hDEADBEEF, 32'h0, 2'b00, 1);

    // Reset: grant must stay low even with requests present.
    rst = 1'b1;
    drive(2'b11, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0);
    tick();
    tick();
    chk("gnt_in_reset", 32'(gnt), 32'h0);
    rst = 1'b0;
    drive(2'b00, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0);
    #1;
    chk("reset_rvalid", 32'(rvalid), 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    chk("reset_ill", 32'(ill), 32'h0);
    chk("reset_rdata0", rdata[0], 32'h0);
    chk("reset_rdata1", rdata[1], 32'h0);
    tick();

    for (int i = 0; i < 13; i++) begin
      drive(vt[i].req, vt[i].a0, vt[i].w0, vt[i].b0, vt[i].d0,
            vt[i].a1, vt[i].w1, vt[i].b1, vt[i].d1);
      #1;
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vt[i].gnt));
      chk($sformatf("v%0d_rvalid", i), 32'(rvalid), 32'(vt[i].rv));
      chk($sformatf("v%0d_err", i), 32'(err & vt[i].rv), 32'(vt[i].er));
      chk($sformatf("v%0d_ill", i), 32'(ill), 32'(vt[i].ill));
      if (vt[i].rv[0]) chk($sformatf("v%0d_rdata0", i), rdata[0], vt[i].rd0);
      if (vt[i].rv[1]) chk($sformatf("v%0d_rdata1", i), rdata[1], vt[i].rd1);
      tick();
    end

    // Reset clears the sticky flag; both ports then alternate 0,1,0,1.
    rst = 1'b1;
    drive(2'b00, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst2_ill", 32'(ill), 32'h0);
    drive(2'b11, 32'h00C, 0, 4'hF, 32'h0, 32'h020, 0, 4'hF, 32'h0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("alt%0d_gnt", k), 32'(gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk($sformatf("alt%0d_rvalid", k), 32'(rvalid),
          (k == 0) ? 32'h0 : ((k % 2 == 1) ? 32'h1 : 32'h2));
      if (k % 2 == 1) chk($sformatf("alt%0d_rdata0", k), rdata[0], 32'd69);
      if (k == 2)     chk($sformatf("alt%0d_rdata1", k), rdata[1], 32'hAA22CC44);
      tick();
    end
    drive(2'b00, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0);
    #1;
    chk("alt_tail_rvalid", 32'(rvalid), 32'h2);
    chk("alt_tail_rdata1", rdata[1], 32'hAA22CC44);
    tick();

    // Read granted, reset asserted the next cycle: its response is dropped.
    drive(2'b01, 32'h00C, 0, 4'hF, 32'h0, 32'h0, 0, 4'h0, 32'h0);
    #1;
    chk("rstmid_gnt", 32'(gnt), 32'h1);
    tick();
    rst = 1'b1;
    drive(2'b00, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0);
    #1;
    chk("rstmid_rvalid_drop", 32'(rvalid), 32'h0);
    chk("rstmid_rdata0", rdata[0], 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("rstmid_after_rvalid", 32'(rvalid), 32'h0);
    chk("rstmid_after_err", 32'(err), 32'h0);
    chk("rstmid_after_ill", 32'(ill), 32'h0);
    drive(2'b11, 32'h00C, 0, 4'hF, 32'h0, 32'h020, 0, 4'hF, 32'h0);
    #1;
    chk("rstmid_rr0_gnt", 32'(gnt), 32'h1);
    tick();
    drive(2'b00, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0);
    #1;
    chk("rstmid_retain_rvalid", 32'(rvalid), 32'h1);
    chk("rstmid_retain_rdata0", rdata[0], 32'd69);
    tick();

`ifdef SRAM_PARITY_EN
    drive(2'b01, 32'h004, 1, 4'hF, 32'h000000FF, 32'h0, 0, 4'h0, 32'h0);
    tick();
    drive(2'b00, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0);
    dut.u_bank.mem[1][0] = 1'b0;
    drive(2'b01, 32'h004, 0, 4'hF, 32'h0, 32'h0, 0, 4'h0, 32'h0);
    tick();
    drive(2'b00, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0);
    #1;
    chk("par_rvalid", 32'(rvalid), 32'h1);
    chk("par_err", 32'(err), 32'h1);
    chk("par_rdata0", rdata[0], 32'h000000FE);
    chk("par_ill", 32'(ill), 32'h0);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
